// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel frame deserializer.
// S2P_PARITY_EN adds the PARITY state to the state encoding.
package s2p_pkg;

  localparam int S2P_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef S2P_PARITY_EN
    PARITY = 2'd2,
`endif
    COMMIT = 2'd3
  } s2p_state_e;

endpackage

// File: rtl/s2p_shift_core.sv
// Shift register with bit-order insert; a start cycle clears the old contents
// and inserts the first bit of a new frame in the same edge.
module s2p_shift_core
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             shift_en,
  input  logic             msb_first,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] word_d, word_q, base;

  always_comb begin
    base   = start ? '0 : word_q;
    word_d = word_q;
    // MSB-first shifts up so the first bit lands in WIDTH-1; LSB-first shifts down to bit 0.
    if (start || shift_en) begin
      word_d = msb_first ? {base[WIDTH-2:0], bit_in} : {bit_in, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/s2p_frame_deser.sv
// Serial-to-parallel frame deserializer: frame FSM, bit counter and status flags.
// Define S2P_PARITY_EN to expect a trailing even-parity bit per frame.
//
// state  | meaning
// IDLE   | no frame in progress, strobes without frame_start are dropped
// SHIFT  | collecting data bits
// PARITY | waiting for the even-parity bit (S2P_PARITY_EN only)
// COMMIT | publishing the assembled word for one cycle
module s2p_frame_deser
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             msb_first,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  s2p_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             msb_d, msb_q;
  logic [WIDTH-1:0] par_out_d, par_out_q;
  logic             par_valid_d, par_valid_q;
  logic             busy_d, busy_q;
  logic             frame_err_d, frame_err_q;
  logic             new_frame, core_start, core_shift, core_msb;
  logic [WIDTH-1:0] core_word;
`ifdef S2P_PARITY_EN
  logic             parity_bit_d, parity_bit_q;
  logic             parity_err_d, parity_err_q;
`endif

  s2p_shift_core #(.WIDTH(WIDTH)) u_shift_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .shift_en  (core_shift),
    .msb_first (core_msb),
    .bit_in    (ser_in),
    .word      (core_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    msb_d       = msb_q;
    par_out_d   = par_out_q;
    par_valid_d = 1'b0;
    frame_err_d = 1'b0;
    core_start  = 1'b0;
    core_shift  = 1'b0;
    core_msb    = msb_q;
    new_frame   = ser_valid & frame_start;
`ifdef S2P_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (new_frame) begin
          frame_err_d = 1'b1;
        end else if (ser_valid) begin
          core_shift = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
`ifdef S2P_PARITY_EN
          if (cnt_q == LAST_CNT) state_d = PARITY;
`else
          if (cnt_q == LAST_CNT) state_d = COMMIT;
`endif
        end
      end
`ifdef S2P_PARITY_EN
      PARITY: begin
        if (new_frame) begin
          frame_err_d = 1'b1;
        end else if (ser_valid) begin
          parity_bit_d = ser_in;
          state_d      = COMMIT;
        end
      end
`endif
      COMMIT: begin
        par_out_d   = core_word;
        par_valid_d = 1'b1;
`ifdef S2P_PARITY_EN
        parity_err_d = (^core_word) != parity_bit_q;
`endif
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A qualified frame_start wins in every state: it aborts or chains into a new frame.
    if (new_frame) begin
      core_start = 1'b1;
      core_msb   = msb_first;
      msb_d      = msb_first;
      cnt_d      = CNT_W'(1);
      state_d    = SHIFT;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      msb_q       <= 1'b0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      msb_q       <= msb_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef S2P_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef S2P_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_frame_deser.sv
// Directed self-checking bench for s2p_frame_deser at WIDTH=8.
// Parity-bit stimulus and parity_err checks follow S2P_PARITY_EN.
module tb_s2p_frame_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       msb_first = 1'b0;
  logic [7:0] par_out;
  logic       par_valid, busy, frame_err, parity_err;

  int n_chk = 0;
  int n_pass = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int busy_lo = 0;
  int pv_base, fe_base;

  s2p_frame_deser #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .msb_first   (msb_first),
    .par_out     (par_out),
    .par_valid   (par_valid),
    .busy        (busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (par_valid === 1'b1) pv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input logic fs, input logic m);
    ser_in      = b;
    ser_valid   = 1'b1;
    frame_start = fs;
    msb_first   = m;
    tick();
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    if (!busy) busy_lo++;
  endtask

  task automatic send_frame(input logic [7:0] word, input logic m, input int gap_max,
                            input logic par);
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && gap_max > 0) begin
        for (int g = 0; g < i % (gap_max + 1); g++) begin
          tick();
          if (!busy) busy_lo++;
        end
      end
      strobe(m ? word[7-i] : word[i], i == 0, m);
    end
`ifdef S2P_PARITY_EN
    strobe(par, 1'b0, m);
`else
    if (par) busy_lo = busy_lo + 0;
`endif
  endtask

  task automatic expect_commit(input string tag, input logic [7:0] exp_word,
                               input logic exp_perr);
    chk({tag, "_pv_early"}, par_valid, 1'b0);
    tick();
    chk({tag, "_pv"}, par_valid, 1'b1);
    chk({tag, "_word"}, par_out, exp_word);
    chk({tag, "_perr"}, parity_err, exp_perr);
    tick();
    chk({tag, "_pv_end"}, par_valid, 1'b0);
    chk({tag, "_perr_end"}, parity_err, 1'b0);
    chk({tag, "_hold"}, par_out, exp_word);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_par_out", par_out, 8'h00);
    chk("rst_par_valid", par_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // LSB-first 1,0,1,1,0,0,1,0 -> 0x4D
    pv_base = pv_cnt;
    strobe(1'b1, 1'b1, 1'b0);
    chk("lsb_busy", busy, 1'b1);
    strobe(1'b0, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0); strobe(1'b0, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0);
`ifdef S2P_PARITY_EN
    strobe(1'b0, 1'b0, 1'b0);
`endif
    expect_commit("lsb", 8'h4D, 1'b0);
    chk("lsb_pv_count", pv_cnt - pv_base, 1);

    // Same bit sequence with MSB-first -> 0xB2
    send_frame(8'hB2, 1'b1, 0, 1'b0);
    expect_commit("msb", 8'hB2, 1'b0);

    // Gaps of 0..3 idle cycles between strobes
    pv_base = pv_cnt;
    busy_lo = 0;
    send_frame(8'h4D, 1'b0, 3, 1'b0);
    chk("gap_busy_lo", busy_lo, 0);
    expect_commit("gap", 8'h4D, 1'b0);
    chk("gap_pv_count", pv_cnt - pv_base, 1);

    // Abort after 3 bits, then a full 0xA5 frame
    pv_base = pv_cnt;
    fe_base = fe_cnt;
    strobe(1'b1, 1'b1, 1'b0); strobe(1'b1, 1'b0, 1'b0); strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b1, 1'b0);
    chk("abort_fe", frame_err, 1'b1);
    chk("abort_hold", par_out, 8'h4D);
    strobe(1'b0, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0); strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0); strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
`ifdef S2P_PARITY_EN
    strobe(1'b0, 1'b0, 1'b0);
`endif
    expect_commit("abort", 8'hA5, 1'b0);
    chk("abort_pv_count", pv_cnt - pv_base, 1);
    chk("abort_fe_count", fe_cnt - fe_base, 1);

    // Next frame started in the COMMIT cycle
    pv_base = pv_cnt;
    fe_base = fe_cnt;
    send_frame(8'h4D, 1'b0, 0, 1'b0);
    strobe(1'b1, 1'b1, 1'b1);
    chk("chain_pv", par_valid, 1'b1);
    chk("chain_word", par_out, 8'h4D);
    chk("chain_busy", busy, 1'b1);
    strobe(1'b0, 1'b0, 1'b1); strobe(1'b1, 1'b0, 1'b1); strobe(1'b1, 1'b0, 1'b1);
    strobe(1'b0, 1'b0, 1'b1); strobe(1'b0, 1'b0, 1'b1); strobe(1'b1, 1'b0, 1'b1);
    strobe(1'b0, 1'b0, 1'b1);
`ifdef S2P_PARITY_EN
    strobe(1'b0, 1'b0, 1'b1);
`endif
    expect_commit("chain2", 8'hB2, 1'b0);
    chk("chain_pv_count", pv_cnt - pv_base, 2);
    chk("chain_fe_count", fe_cnt - fe_base, 0);

    // Strobes without frame_start and frame_start without strobe are ignored in IDLE
    pv_base = pv_cnt;
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1);
    chk("drop_busy", busy, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("fs_novalid_busy", busy, 1'b0);
    tick();
    chk("drop_pv_count", pv_cnt - pv_base, 0);

    // Reset after 5 bits
    pv_base = pv_cnt;
    fe_base = fe_cnt;
    strobe(1'b1, 1'b1, 1'b0); strobe(1'b0, 1'b0, 1'b0); strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0); strobe(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_par_out", par_out, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pv", par_valid, 1'b0);
    chk("mid_rst_fe", frame_err, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_pv_count", pv_cnt - pv_base, 0);
    chk("mid_rst_fe_count", fe_cnt - fe_base, 0);
    send_frame(8'h4D, 1'b0, 0, 1'b0);
    expect_commit("post_rst", 8'h4D, 1'b0);

`ifdef S2P_PARITY_EN
    // 0x4D has even weight, so a parity bit of 1 is a mismatch
    send_frame(8'h4D, 1'b0, 0, 1'b1);
    expect_commit("par_bad", 8'h4D, 1'b1);
    send_frame(8'h4D, 1'b0, 2, 1'b0);
    expect_commit("par_good", 8'h4D, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/s2p_frame_deser.md
S2P_FRAME_DESER -- requirements
Module: s2p_frame_deser

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ser_in  input  1  serial data bit, sampled only when ser_valid=1.
REQ-005 ser_valid  input  1  bit strobe; one bit consumed per cycle with ser_valid=1.
REQ-006 frame_start  input  1  qualifies the current ser_valid bit as bit 0 of a new frame.
REQ-007 msb_first  input  1  bit order, 1=MSB first, 0=LSB first; sampled with bit 0 only.
REQ-008 par_out  output  WIDTH  last committed word; held between commits.
REQ-009 par_valid  output  1  one-cycle pulse marking a new par_out.
REQ-010 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-011 frame_err  output  1  one-cycle pulse when a frame is aborted by frame_start.
REQ-012 parity_err  output  1  one-cycle pulse, coincident with par_valid, on parity mismatch (S2P_PARITY_EN only; tied 0 otherwise).

Function
REQ-013 States: IDLE, SHIFT, PARITY (S2P_PARITY_EN only), COMMIT.
REQ-014 IDLE: ser_valid=1 and frame_start=1 -> capture bit 0, latch msb_first, bit count=1, go SHIFT; ser_valid=1 without frame_start -> bit dropped, stay IDLE.
REQ-015 SHIFT: each ser_valid=1 cycle captures one bit and increments bit count; ser_valid=0 cycles hold state (arbitrary gaps allowed).
REQ-016 Bit order: MSB-first captures the first bit into par bit WIDTH-1; LSB-first captures it into bit 0.
REQ-017 After the WIDTH-th bit: go PARITY if S2P_PARITY_EN is defined, else COMMIT.
REQ-018 PARITY: next ser_valid=1 bit is the even-parity bit; capture it, go COMMIT.
REQ-019 COMMIT (one cycle): par_out <= assembled word, par_valid=1, parity_err set if (XOR of data bits) != parity bit; next state IDLE.
REQ-020 Latency: par_valid asserts exactly one cycle after the edge that samples the final bit (data or parity).
REQ-021 In COMMIT, ser_valid=1 with frame_start=1 starts the next frame (bit 0 captured, go SHIFT); ser_valid=1 without frame_start drops the bit.
REQ-022 In SHIFT or PARITY, ser_valid=1 with frame_start=1 aborts the current frame: frame_err pulses next cycle, partial word discarded, par_out unchanged, the strobed bit becomes bit 0 of a new frame.
REQ-023 frame_start with ser_valid=0 has no effect.
REQ-024 Bit counter width is clog2(WIDTH+1); no wrap inside a frame.

Reset
REQ-025 rst_n=0 at a rising edge: state IDLE, bit count 0, shift register 0, par_out 0, par_valid 0, busy 0, frame_err 0, parity_err 0.
REQ-026 Reset mid-frame discards the partial word with no par_valid or frame_err pulse.

Configuration
REQ-027 Macro S2P_PARITY_EN defined: PARITY state present; each frame is WIDTH data bits plus 1 even-parity bit; parity_err active.
REQ-028 S2P_PARITY_EN undefined: PARITY state absent; frame is WIDTH bits; parity_err constant 0.

Structure
REQ-029 Package s2p_pkg holds the state enum type and constant S2P_DEFAULT_WIDTH=8.
REQ-030 Sub-module s2p_shift_core (shift register plus bit-order insert, WIDTH-parametrised) is instantiated once; the FSM, counter and flags stay in s2p_frame_deser.

Verification (WIDTH=8)
REQ-031 LSB-first bits 1,0,1,1,0,0,1,0 (frame_start with first) -> par_out=8'h4D, par_valid one cycle after the last bit.
REQ-032 Same bits with msb_first=1 -> par_out=8'hB2.
REQ-033 Bits sent with 0-3 idle cycles between strobes -> same 8'h4D, busy high throughout, single par_valid pulse.
REQ-034 frame_start after 3 bits, then 8 bits of 8'hA5 -> frame_err pulse, then par_out=8'hA5, exactly one par_valid.
REQ-035 rst_n=0 after 5 bits -> all outputs 0, no pulses; next full frame decodes correctly.
REQ-036 S2P_PARITY_EN: 8'h4D with parity 0 -> parity_err=0; with parity 1 -> parity_err=1, coincident with par_valid.
